resv_sched_pip0: RTL and testbench

- Scheduler/controller for one 8-cell collapsing reservation station (cell 0 = oldest).
- Tracks occupancy and generates the per-cell insert and shift address buses.
- Arbitrates ready cells onto execution pipes 0/1, at most one issue per cycle.
- Handles pipeline flush by clearing all cells.

---
 rtl/resv_sched_pip0_pkg.sv | 10 +
 rtl/resv_sched_pip0_if.sv | 33 +++
 rtl/resv_sched_pip0_oldest_pick.sv | 22 ++
 rtl/resv_sched_pip0.sv | 118 +++++++++++
 tb/tb_resv_sched_pip0.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/resv_sched_pip0_pkg.sv
// Shared sizing, idle code and FSM state type for the reservation-station scheduler.
package resv_sched_pkg;

    localparam int N_CELL  = 8;
    localparam int W_ident = 4;
    localparam logic [W_ident-1:0] UNUSED_CD = {W_ident{1'b1}};

    typedef enum logic {S_RUN, S_FLUSH} state_t;

endpackage

// File: rtl/resv_sched_pip0_if.sv
// Decoder, cell-array and pipe signals of the scheduler. The scheduler uses the
// slave modport; the surrounding datapath or a testbench uses master.
interface resv_sched_pip0_if;
    import resv_sched_pkg::*;

    logic                        flush;
    logic                        dec_valid;
    logic                        dec_ready;
    logic [N_CELL*W_ident-1:0]   candit0_bus;
    logic [N_CELL*W_ident-1:0]   candit1_bus;
    logic                        ex0_ready;
    logic                        ex1_ready;
    logic                        iss0_valid;
    logic                        iss1_valid;
    logic [W_ident-1:0]          iss_addr;
    logic [W_ident-1:0]          addr_insert;
    logic [W_ident-1:0]          addr_shift;
    logic                        cell_clear;
    logic [W_ident-1:0]          count;

    modport master (
        output flush, dec_valid, candit0_bus, candit1_bus, ex0_ready, ex1_ready,
        input  dec_ready, iss0_valid, iss1_valid, iss_addr, addr_insert,
               addr_shift, cell_clear, count
    );

    modport slave (
        input  flush, dec_valid, candit0_bus, candit1_bus, ex0_ready, ex1_ready,
        output dec_ready, iss0_valid, iss1_valid, iss_addr, addr_insert,
               addr_shift, cell_clear, count
    );

endinterface

// File: rtl/resv_sched_pip0_oldest_pick.sv
// Combinational lowest-index encoder: the oldest valid cell wins.
module resv_oldest_pick
    import resv_sched_pkg::*;
(
    input  logic [N_CELL-1:0]  valid_i,
    output logic               found_o,
    output logic [W_ident-1:0] idx_o
);

    // Scanning from the top down lets the lowest set bit overwrite any higher one.
    always_comb begin
        found_o = 1'b0;
        idx_o   = UNUSED_CD;
        for (int k = N_CELL - 1; k >= 0; k--) begin
            if (valid_i[k]) begin
                found_o = 1'b1;
                idx_o   = W_ident'(k);
            end
        end
    end

endmodule

// File: rtl/resv_sched_pip0.sv
// Scheduler for one 8-cell collapsing reservation station: occupancy, insert/shift
// addressing, single-issue arbitration onto two pipes, flush. RESV_SCHED_RR_EN enables pipe round-robin.
module resv_sched_pip0
    import resv_sched_pkg::*;
(
    input  logic               clk,
    input  logic               clear,
    resv_sched_pip0_if.slave   rs
);

    state_t             state_q, state_d;
    logic [W_ident-1:0] count_q, count_d;

    logic [N_CELL-1:0]  elig0, elig1;
    logic               found0, found1;
    logic [W_ident-1:0] idx0, idx1;
    logic               runOk;
    logic               grant0, grant1, issuing;
    logic               inserting;
    logic               decReady;

`ifdef RESV_SCHED_RR_EN
    logic prio_q, prio_d;
`endif

    // A cell is a candidate only if it reports its own index and lies below the occupancy mark.
    always_comb begin
        elig0 = '0;
        elig1 = '0;
        for (int k = 0; k < N_CELL; k++) begin
            elig0[k] = rs.ex0_ready && (W_ident'(k) < count_q)
                       && (rs.candit0_bus[k*W_ident +: W_ident] == W_ident'(k));
            elig1[k] = rs.ex1_ready && (W_ident'(k) < count_q)
                       && (rs.candit1_bus[k*W_ident +: W_ident] == W_ident'(k));
        end
    end

    resv_oldest_pick u_pick0 (.valid_i(elig0), .found_o(found0), .idx_o(idx0));
    resv_oldest_pick u_pick1 (.valid_i(elig1), .found_o(found1), .idx_o(idx1));

    always_comb begin
        runOk  = !clear && (state_q == S_RUN) && !rs.flush;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (runOk) begin
            if (found0 && found1) begin
`ifdef RESV_SCHED_RR_EN
                grant0 = !prio_q;
`else
                grant0 = (idx0 <= idx1);
`endif
                grant1 = !grant0;
            end else begin
                grant0 = found0;
                grant1 = found1;
            end
        end
        issuing   = grant0 || grant1;
        decReady  = runOk && ((count_q < W_ident'(N_CELL)) || issuing);
        inserting = rs.dec_valid && decReady;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_RUN;
            count_q <= '0;
`ifdef RESV_SCHED_RR_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
`ifdef RESV_SCHED_RR_EN
            prio_q  <= prio_d;
`endif
        end
    end

    // Insert and issue never over/underflow: insert needs room or a leaving cell, issue needs a valid cell.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_RUN: begin
                if (rs.flush) begin
                    state_d = S_FLUSH;
                    count_d = '0;
                end else begin
                    count_d = count_q + W_ident'(inserting) - W_ident'(issuing);
                end
            end
            S_FLUSH: begin
                count_d = '0;
                if (!rs.flush) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
`ifdef RESV_SCHED_RR_EN
        prio_d = prio_q ^ (issuing && found0 && found1);
`endif
    end

    // With a simultaneous issue the cells above the issued one collapse, so the insert slot moves down by one.
    always_comb begin
        rs.iss0_valid  = grant0;
        rs.iss1_valid  = grant1;
        rs.iss_addr    = grant0 ? idx0 : (grant1 ? idx1 : UNUSED_CD);
        rs.addr_shift  = grant0 ? idx0 : (grant1 ? idx1 : UNUSED_CD);
        rs.dec_ready   = decReady;
        rs.addr_insert = UNUSED_CD;
        if (inserting) begin
            rs.addr_insert = issuing ? (count_q - W_ident'(1)) : count_q;
        end
        rs.cell_clear  = clear || (state_q == S_FLUSH) || rs.flush;
        rs.count       = count_q;
    end

endmodule

// File: tb/tb_resv_sched_pip0.sv
// Directed self-checking bench for resv_sched_pip0; RR steps run when RESV_SCHED_RR_EN is defined.
module tb_resv_sched_pip0;
    import resv_sched_pkg::*;

    logic clk;
    logic clear;
    int   passCount;
    int   checkCount;

    resv_sched_pip0_if rsIf ();

    resv_sched_pip0 dut (
        .clk   (clk),
        .clear (clear),
        .rs    (rsIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic fl, input logic dv, input logic r0, input logic r1,
                                 input int c0, input int c1);
        logic [N_CELL*W_ident-1:0] b0, b1;
        b0 = '1;
        b1 = '1;
        if (c0 >= 0) b0[c0*W_ident +: W_ident] = W_ident'(c0);
        if (c1 >= 0) b1[c1*W_ident +: W_ident] = W_ident'(c1);
        rsIf.flush       = fl;
        rsIf.dec_valid   = dv;
        rsIf.ex0_ready   = r0;
        rsIf.ex1_ready   = r1;
        rsIf.candit0_bus = b0;
        rsIf.candit1_bus = b1;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fillTo(input int n);
        clear = 1'b1;
        applyStimulus(0, 0, 0, 0, -1, -1);
        step();
        clear = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 1, 0, 0, -1, -1);
            step();
        end
        applyStimulus(0, 0, 0, 0, -1, -1);
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        clear      = 1'b1;
        applyStimulus(0, 0, 0, 0, -1, -1);
        @(negedge clk);

        checkOutput("rst_cell_clear", {7'b0, rsIf.cell_clear}, 8'h01);
        checkOutput("rst_dec_ready", {7'b0, rsIf.dec_ready}, 8'h00);
        checkOutput("rst_iss_addr", {4'b0, rsIf.iss_addr}, 8'h0f);
        checkOutput("rst_addr_insert", {4'b0, rsIf.addr_insert}, 8'h0f);
        checkOutput("rst_addr_shift", {4'b0, rsIf.addr_shift}, 8'h0f);
        step();
        clear = 1'b0;
        #1;
        checkOutput("rst_count", {4'b0, rsIf.count}, 8'h00);
        checkOutput("rst_iss0", {7'b0, rsIf.iss0_valid}, 8'h00);

        for (int i = 0; i < N_CELL; i++) begin
            applyStimulus(0, 1, 0, 0, -1, -1);
            checkOutput("fill_insert", {4'b0, rsIf.addr_insert}, 8'(i));
            checkOutput("fill_ready", {7'b0, rsIf.dec_ready}, 8'h01);
            checkOutput("fill_shift", {4'b0, rsIf.addr_shift}, 8'h0f);
            step();
        end
        checkOutput("full_count", {4'b0, rsIf.count}, 8'h08);
        checkOutput("full_ready", {7'b0, rsIf.dec_ready}, 8'h00);
        checkOutput("full_insert", {4'b0, rsIf.addr_insert}, 8'h0f);
        checkOutput("full_cell_clear", {7'b0, rsIf.cell_clear}, 8'h00);

        fillTo(5);
        applyStimulus(0, 0, 1, 0, 1, -1);
        rsIf.candit0_bus[3*W_ident +: W_ident] = 4'd3;
        #1;
        checkOutput("old_iss_addr", {4'b0, rsIf.iss_addr}, 8'h01);
        checkOutput("old_iss0", {7'b0, rsIf.iss0_valid}, 8'h01);
        checkOutput("old_iss1", {7'b0, rsIf.iss1_valid}, 8'h00);
        checkOutput("old_shift", {4'b0, rsIf.addr_shift}, 8'h01);
        step();
        checkOutput("old_count", {4'b0, rsIf.count}, 8'h04);

        fillTo(6);
        applyStimulus(0, 0, 1, 1, 4, 2);
`ifdef RESV_SCHED_RR_EN
        checkOutput("cross_iss_addr", {4'b0, rsIf.iss_addr}, 8'h04);
        checkOutput("cross_iss0", {7'b0, rsIf.iss0_valid}, 8'h01);
`else
        checkOutput("cross_iss_addr", {4'b0, rsIf.iss_addr}, 8'h02);
        checkOutput("cross_iss1", {7'b0, rsIf.iss1_valid}, 8'h01);
        checkOutput("cross_iss0", {7'b0, rsIf.iss0_valid}, 8'h00);
`endif
        applyStimulus(0, 0, 1, 0, 4, 2);
        checkOutput("cross_ex1_off_addr", {4'b0, rsIf.iss_addr}, 8'h04);
        checkOutput("cross_ex1_off_iss0", {7'b0, rsIf.iss0_valid}, 8'h01);
        checkOutput("cross_ex1_off_iss1", {7'b0, rsIf.iss1_valid}, 8'h00);
        applyStimulus(0, 0, 1, 1, 7, -1);
        checkOutput("above_count_iss0", {7'b0, rsIf.iss0_valid}, 8'h00);

        fillTo(8);
        applyStimulus(0, 1, 1, 0, 0, -1);
        checkOutput("fpi_ready", {7'b0, rsIf.dec_ready}, 8'h01);
        checkOutput("fpi_shift", {4'b0, rsIf.addr_shift}, 8'h00);
        checkOutput("fpi_insert", {4'b0, rsIf.addr_insert}, 8'h07);
        step();
        checkOutput("fpi_count", {4'b0, rsIf.count}, 8'h08);

        fillTo(6);
        applyStimulus(1, 1, 1, 1, 1, 2);
        checkOutput("fl_iss0", {7'b0, rsIf.iss0_valid}, 8'h00);
        checkOutput("fl_iss1", {7'b0, rsIf.iss1_valid}, 8'h00);
        checkOutput("fl_cell_clear", {7'b0, rsIf.cell_clear}, 8'h01);
        checkOutput("fl_ready", {7'b0, rsIf.dec_ready}, 8'h00);
        checkOutput("fl_insert", {4'b0, rsIf.addr_insert}, 8'h0f);
        step();
        applyStimulus(1, 1, 1, 1, -1, -1);
        checkOutput("fl_hold_cell_clear", {7'b0, rsIf.cell_clear}, 8'h01);
        checkOutput("fl_hold_count", {4'b0, rsIf.count}, 8'h00);
        step();
        applyStimulus(0, 1, 1, 1, 0, -1);
        checkOutput("fl2_cell_clear", {7'b0, rsIf.cell_clear}, 8'h01);
        checkOutput("fl2_ready", {7'b0, rsIf.dec_ready}, 8'h00);
        checkOutput("fl2_iss0", {7'b0, rsIf.iss0_valid}, 8'h00);
        step();
        checkOutput("post_fl_count", {4'b0, rsIf.count}, 8'h00);
        checkOutput("post_fl_cell_clear", {7'b0, rsIf.cell_clear}, 8'h00);
        checkOutput("post_fl_ready", {7'b0, rsIf.dec_ready}, 8'h01);
        checkOutput("post_fl_insert", {4'b0, rsIf.addr_insert}, 8'h00);
        checkOutput("empty_iss0", {7'b0, rsIf.iss0_valid}, 8'h00);
        checkOutput("empty_shift", {4'b0, rsIf.addr_shift}, 8'h0f);
        step();
        checkOutput("post_fl_count1", {4'b0, rsIf.count}, 8'h01);

`ifdef RESV_SCHED_RR_EN
        fillTo(8);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 1, 0, 1);
            checkOutput("rr_iss0", {7'b0, rsIf.iss0_valid}, 8'((i % 2) == 0));
            checkOutput("rr_iss1", {7'b0, rsIf.iss1_valid}, 8'((i % 2) == 1));
            checkOutput("rr_addr", {4'b0, rsIf.iss_addr}, 8'(i % 2));
            step();
            checkOutput("rr_count", {4'b0, rsIf.count}, 8'h08);
        end
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
